// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO; 34 cycles start-to-done, start ignored while busy (core stalls on busy).
// Optional MULDIV_CANCEL_EN adds a cancel input that aborts an in-flight operation without touching HI/LO.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
`ifdef MULDIV_CANCEL_EN
  input  logic             cancel,
`endif
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 bz_q, bz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;

  logic                 cancel_i;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic                 last_step;

`ifdef MULDIV_CANCEL_EN
  assign cancel_i = cancel;
`else
  assign cancel_i = 1'b0;
`endif

  // op[0] selects the signed flavour; magnitudes go through the unsigned datapath.
  assign a_neg = op[0] & src_a[WIDTH-1];
  assign b_neg = op[0] & src_b[WIDTH-1];
  assign a_abs = a_neg ? -src_a : src_a;
  assign b_abs = b_neg ? -src_b : src_b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign last_step = (cnt_q == CNT_W'(WIDTH-1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    bz_d      = bz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // start takes precedence; a coincident MTHI/MTLO is dropped
          state_d   = RUN;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          bz_d      = op[1] & (src_b == '0);
          opnd_d    = op[1] ? b_abs : a_abs;
          acc_d     = op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
        end else begin
          if (hi_we) hi_d = wr_data;
          if (lo_we) lo_d = wr_data;
        end
      end

      RUN: begin
        if (cancel_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (is_div_q) begin
            if (!div_diff[WIDTH])
              acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
              acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (last_step) begin
            state_d = FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      FIX: begin
        state_d = IDLE;
        if (!cancel_i) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // zero divisor: restoring loop leaves |a| as remainder, so rem_fix == src_a
            hi_d = rem_fix;
            lo_d = bz_q ? '1 : quo_fix;
            dz_d = bz_q;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      bz_q      <= bz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
